// File: rtl/rs_deint_sched_if.sv
// rs_deint_sched_if
// -----------------
// Bundles the byte-stream input, codeword-buffer write port and decoder
// start/done handshake of rs_deint_sched.
//
//   new_cvcdu       first byte of a CVCDU (qualified by byte_valid_in)
//   byte_valid_in   byte_in valid
//   byte_in[7:0]    CVCDU byte
//   wr_en_out       codeword buffer write strobe
//   wr_addr_out     buffer address cw*N + sym
//   wr_data_out     byte to write
//   dec_start_out   one-cycle decoder start pulse
//   dec_cw_idx_out  codeword index handed to the decoder
//   dec_done_in     one-cycle decoder completion pulse
//   frame_done_out  pulse after the last codeword completes
//   overrun_out     pulse when a valid byte is dropped
//   sync_err_out    pulse when new_cvcdu arrives mid-frame
//   frame_cnt_out   completed-frame counter (only with RS_FRAME_CNT_EN)
//
// slave  : the scheduler side
// master : the side driving the byte stream and modelling the decoder
interface rs_deint_sched_if;
    logic        new_cvcdu;
    logic        byte_valid_in;
    logic [7:0]  byte_in;
    logic        wr_en_out;
    logic [9:0]  wr_addr_out;
    logic [7:0]  wr_data_out;
    logic        dec_start_out;
    logic [1:0]  dec_cw_idx_out;
    logic        dec_done_in;
    logic        frame_done_out;
    logic        overrun_out;
    logic        sync_err_out;
`ifdef RS_FRAME_CNT_EN
    logic [15:0] frame_cnt_out;

    modport slave (
        input  new_cvcdu, byte_valid_in, byte_in, dec_done_in,
        output wr_en_out, wr_addr_out, wr_data_out, dec_start_out,
               dec_cw_idx_out, frame_done_out, overrun_out, sync_err_out,
               frame_cnt_out
    );

    modport master (
        output new_cvcdu, byte_valid_in, byte_in, dec_done_in,
        input  wr_en_out, wr_addr_out, wr_data_out, dec_start_out,
               dec_cw_idx_out, frame_done_out, overrun_out, sync_err_out,
               frame_cnt_out
    );
`else
    modport slave (
        input  new_cvcdu, byte_valid_in, byte_in, dec_done_in,
        output wr_en_out, wr_addr_out, wr_data_out, dec_start_out,
               dec_cw_idx_out, frame_done_out, overrun_out, sync_err_out
    );

    modport master (
        output new_cvcdu, byte_valid_in, byte_in, dec_done_in,
        input  wr_en_out, wr_addr_out, wr_data_out, dec_start_out,
               dec_cw_idx_out, frame_done_out, overrun_out, sync_err_out
    );
`endif
endinterface

// File: rtl/rs_deint_sched.sv
// rs_deint_sched
// --------------
// De-interleaves each 1020-byte CVCDU (depth 4) into four 255-byte RS
// codewords by generating codeword-buffer write addresses, then hands the
// codewords to the RS decoder one at a time over a start/done handshake.
//
// Ports:
//   clk_in  system clock
//   rst_in  synchronous active-low reset
//   bus     rs_deint_sched_if.slave (byte stream, buffer write, decoder
//           handshake, status pulses; see the interface file)
//
// Optional feature: define RS_FRAME_CNT_EN to add bus.frame_cnt_out, a
// 16-bit wrapping count of frame_done_out pulses.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a byte carrying new_cvcdu; other bytes discarded
// FILL  | writing bytes k=1..1019 into the buffer
// START | frame complete; issue the start pulse for codeword 0
// WAIT  | decoder busy on dec_cw_idx_out; done starts the next codeword
//       | directly, or ends the frame after codeword 3
module rs_deint_sched #(
    parameter int DEPTH = 4,
    parameter int N     = 255
) (
    input  logic            clk_in,
    input  logic            rst_in,
    rs_deint_sched_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] START = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;

    localparam logic [1:0] CW_LAST  = 2'(DEPTH - 1);
    localparam logic [7:0] SYM_LAST = 8'(N - 1);

    logic [1:0] state;
    logic [1:0] cw;
    logic [7:0] sym;
    logic [1:0] dec_idx;

    logic       wr_en_q;
    logic [9:0] wr_addr_q;
    logic [7:0] wr_data_q;
    logic       dec_start_q;
    logic       frame_done_q;
    logic       overrun_q;
    logic       sync_err_q;

    logic [9:0] addr_calc;
    logic       mid_frame;
    logic       last_byte;

    assign addr_calc = 10'(cw) * 10'(N) + 10'(sym);
    assign mid_frame = (cw != 2'd0) || (sym != 8'd0);
    assign last_byte = (cw == CW_LAST) && (sym == SYM_LAST);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state        <= IDLE;
            cw           <= 2'd0;
            sym          <= 8'd0;
            dec_idx      <= 2'd0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 10'd0;
            wr_data_q    <= 8'd0;
            dec_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            wr_en_q      <= 1'b0;
            dec_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            sync_err_q   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.byte_valid_in && bus.new_cvcdu) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= 10'd0;
                        wr_data_q <= bus.byte_in;
                        cw        <= 2'd1;
                        sym       <= 8'd0;
                        state     <= FILL;
                    end
                end

                FILL: begin
                    if (bus.byte_valid_in) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= bus.byte_in;
                        if (bus.new_cvcdu && mid_frame) begin
                            // Resynchronise: this byte becomes k=0 of a new frame.
                            sync_err_q <= 1'b1;
                            wr_addr_q  <= 10'd0;
                            cw         <= 2'd1;
                            sym        <= 8'd0;
                        end else begin
                            wr_addr_q <= addr_calc;
                            if (last_byte) begin
                                cw    <= 2'd0;
                                sym   <= 8'd0;
                                state <= START;
                            end else begin
                                cw <= cw + 2'd1;
                                if (cw == CW_LAST) begin
                                    sym <= sym + 8'd1;
                                end
                            end
                        end
                    end
                end

                START: begin
                    overrun_q   <= bus.byte_valid_in;
                    dec_start_q <= 1'b1;
                    state       <= WAIT;
                end

                WAIT: begin
                    overrun_q <= bus.byte_valid_in;
                    if (bus.dec_done_in) begin
                        if (dec_idx != CW_LAST) begin
                            // Start the next codeword straight away so it follows
                            // done by a single cycle.
                            dec_idx     <= dec_idx + 2'd1;
                            dec_start_q <= 1'b1;
                        end else begin
                            dec_idx      <= 2'd0;
                            frame_done_q <= 1'b1;
                            state        <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef RS_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            frame_cnt <= 16'd0;
        end else if (frame_done_q) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign bus.frame_cnt_out = frame_cnt;
`endif

    assign bus.wr_en_out      = wr_en_q;
    assign bus.wr_addr_out    = wr_addr_q;
    assign bus.wr_data_out    = wr_data_q;
    assign bus.dec_start_out  = dec_start_q;
    assign bus.dec_cw_idx_out = dec_idx;
    assign bus.frame_done_out = frame_done_q;
    assign bus.overrun_out    = overrun_q;
    assign bus.sync_err_out   = sync_err_q;

endmodule

// File: tb/tb_rs_deint_sched.sv
// tb_rs_deint_sched
// -----------------
// Directed bench for rs_deint_sched: address mapping, decoder dispatch
// timing, resync, overrun, mid-frame reset and pre-sync discard.
module tb_rs_deint_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs_deint_sched_if ifc ();

    rs_deint_sched #(.DEPTH(4), .N(255)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (ifc.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec  = 0;
    int miss = 0;

    logic [9:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];
    int         st_idx_q[$];
    int         st_cyc_q[$];
    int         fd_cyc_q[$];
    int         ovr_cnt  = 0;
    int         serr_cnt = 0;
    int         done_cyc[4];
    int         last_wr_cyc;

    always @(negedge clk) begin
        if (ifc.wr_en_out) begin
            wr_addr_q.push_back(ifc.wr_addr_out);
            wr_data_q.push_back(ifc.wr_data_out);
            wr_cyc_q.push_back(cyc);
        end
        if (ifc.dec_start_out) begin
            st_idx_q.push_back(int'(ifc.dec_cw_idx_out));
            st_cyc_q.push_back(cyc);
        end
        if (ifc.frame_done_out) fd_cyc_q.push_back(cyc);
        if (ifc.overrun_out)    ovr_cnt++;
        if (ifc.sync_err_out)   serr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        st_idx_q.delete();
        st_cyc_q.delete();
        fd_cyc_q.delete();
        ovr_cnt  = 0;
        serr_cnt = 0;
    endtask

    task automatic idle_inputs();
        ifc.byte_valid_in = 1'b0;
        ifc.new_cvcdu     = 1'b0;
        ifc.byte_in       = 8'h00;
        ifc.dec_done_in   = 1'b0;
    endtask

    // Bytes k0..k1 back to back; byte value is k*7+seed.
    task automatic send_bytes(input int k0, input int k1, input bit new_first, input int seed);
        for (int k = k0; k <= k1; k++) begin
            ifc.byte_valid_in = 1'b1;
            ifc.new_cvcdu     = new_first && (k == k0);
            ifc.byte_in       = 8'(k * 7 + seed);
            tick();
        end
        ifc.byte_valid_in = 1'b0;
        ifc.new_cvcdu     = 1'b0;
    endtask

    // Decoder model: answers each start with done after lat cycles.
    // With inject set, three bytes (one carrying new_cvcdu) arrive while
    // codeword 1 is being decoded.
    task automatic decode_all(input int lat, input bit inject);
        int n;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!ifc.dec_start_out && n < 3000) begin
                tick();
                n++;
            end
            if (n >= 3000) begin
                vec++;
                miss++;
                $display("FAIL dec_start_wait cw=%0d: no start pulse seen, required one within 3000 cycles", i);
                return;
            end
            for (int j = 0; j < lat; j++) begin
                if (inject && i == 1 && j >= 2 && j <= 4) begin
                    ifc.byte_valid_in = 1'b1;
                    ifc.new_cvcdu     = (j == 3);
                    ifc.byte_in       = 8'hEE;
                end else begin
                    ifc.byte_valid_in = 1'b0;
                    ifc.new_cvcdu     = 1'b0;
                end
                tick();
            end
            ifc.byte_valid_in = 1'b0;
            ifc.new_cvcdu     = 1'b0;
            ifc.dec_done_in   = 1'b1;
            done_cyc[i]       = cyc;
            tick();
            ifc.dec_done_in   = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        vec++; if (ifc.wr_en_out !== 1'b0)      begin miss++; $display("FAIL reset_wr_en got %b want 0", ifc.wr_en_out); end
        vec++; if (ifc.wr_addr_out !== 10'd0)   begin miss++; $display("FAIL reset_wr_addr got %0d want 0", ifc.wr_addr_out); end
        vec++; if (ifc.wr_data_out !== 8'd0)    begin miss++; $display("FAIL reset_wr_data got %0h want 0", ifc.wr_data_out); end
        vec++; if (ifc.dec_start_out !== 1'b0)  begin miss++; $display("FAIL reset_dec_start got %b want 0", ifc.dec_start_out); end
        vec++; if (ifc.dec_cw_idx_out !== 2'd0) begin miss++; $display("FAIL reset_cw_idx got %0d want 0", ifc.dec_cw_idx_out); end
        vec++; if (ifc.frame_done_out !== 1'b0) begin miss++; $display("FAIL reset_frame_done got %b want 0", ifc.frame_done_out); end
        vec++; if (ifc.overrun_out !== 1'b0)    begin miss++; $display("FAIL reset_overrun got %b want 0", ifc.overrun_out); end
        vec++; if (ifc.sync_err_out !== 1'b0)   begin miss++; $display("FAIL reset_sync_err got %b want 0", ifc.sync_err_out); end
`ifdef RS_FRAME_CNT_EN
        vec++; if (ifc.frame_cnt_out !== 16'd0) begin miss++; $display("FAIL reset_frame_cnt got %0d want 0", ifc.frame_cnt_out); end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_stray();
        clear_mon();
        send_bytes(0, 19, 1'b0, 1);
        ifc.dec_done_in = 1'b1;
        tick();
        ifc.dec_done_in = 1'b0;
        repeat (3) tick();
        vec++; if (wr_addr_q.size() != 0) begin miss++; $display("FAIL idle_writes got %0d want 0", wr_addr_q.size()); end
        vec++; if (st_idx_q.size() != 0)  begin miss++; $display("FAIL idle_starts got %0d want 0", st_idx_q.size()); end
        vec++; if (fd_cyc_q.size() != 0)  begin miss++; $display("FAIL idle_frame_done got %0d want 0", fd_cyc_q.size()); end
        vec++; if (ovr_cnt != 0)          begin miss++; $display("FAIL idle_overrun got %0d want 0", ovr_cnt); end
        vec++; if (serr_cnt != 0)         begin miss++; $display("FAIL idle_sync_err got %0d want 0", serr_cnt); end
    endtask

    // Leaves the DUT at the first start pulse; test_decode must follow.
    task automatic test_addr_map();
        logic [9:0] ea;
        logic [7:0] ed;
        int         nbad;
        clear_mon();
        send_bytes(0, 1019, 1'b1, 3);
        tick();
        vec++; if (wr_addr_q.size() != 1020) begin miss++; $display("FAIL map_write_count got %0d want 1020", wr_addr_q.size()); end
        if (wr_addr_q.size() == 1020) begin
            vec++; if (wr_addr_q[1] !== 10'd255)  begin miss++; $display("FAIL map_addr_k1 got %0d want 255", wr_addr_q[1]); end
            vec++; if (wr_addr_q[3] !== 10'd765)  begin miss++; $display("FAIL map_addr_k3 got %0d want 765", wr_addr_q[3]); end
            vec++; if (wr_addr_q[5] !== 10'd256)  begin miss++; $display("FAIL map_addr_k5 got %0d want 256", wr_addr_q[5]); end
            vec++; if (wr_addr_q[1019] !== 10'd1019) begin miss++; $display("FAIL map_addr_k1019 got %0d want 1019", wr_addr_q[1019]); end
            nbad = 0;
            for (int k = 0; k < 1020; k++) begin
                ea = 10'((k % 4) * 255 + (k / 4));
                ed = 8'(k * 7 + 3);
                vec++;
                if (wr_addr_q[k] !== ea || wr_data_q[k] !== ed) begin
                    miss++;
                    if (nbad < 8) $display("FAIL map_write k=%0d got addr %0d data %0h want addr %0d data %0h",
                                           k, wr_addr_q[k], wr_data_q[k], ea, ed);
                    nbad++;
                end
            end
            last_wr_cyc = wr_cyc_q[1019];
        end else begin
            last_wr_cyc = cyc - 1;
        end
    endtask

    task automatic test_decode();
        clear_mon();
        decode_all(10, 1'b0);
        repeat (3) tick();
        vec++; if (st_idx_q.size() != 4) begin miss++; $display("FAIL dec_start_count got %0d want 4", st_idx_q.size()); end
        if (st_idx_q.size() == 4) begin
            vec++; if (st_cyc_q[0] != last_wr_cyc + 1) begin miss++; $display("FAIL dec_first_start_cycle got %0d want %0d", st_cyc_q[0], last_wr_cyc + 1); end
            for (int i = 0; i < 4; i++) begin
                vec++; if (st_idx_q[i] != i) begin miss++; $display("FAIL dec_start_idx n=%0d got %0d want %0d", i, st_idx_q[i], i); end
            end
            for (int i = 1; i < 4; i++) begin
                vec++; if (st_cyc_q[i] != done_cyc[i-1] + 1) begin miss++; $display("FAIL dec_start_after_done n=%0d got cycle %0d want %0d", i, st_cyc_q[i], done_cyc[i-1] + 1); end
            end
        end
        vec++; if (fd_cyc_q.size() != 1) begin miss++; $display("FAIL dec_frame_done_count got %0d want 1", fd_cyc_q.size()); end
        if (fd_cyc_q.size() == 1) begin
            vec++; if (fd_cyc_q[0] != done_cyc[3] + 1) begin miss++; $display("FAIL dec_frame_done_cycle got %0d want %0d", fd_cyc_q[0], done_cyc[3] + 1); end
        end
        vec++; if (ifc.dec_cw_idx_out !== 2'd0) begin miss++; $display("FAIL dec_idx_cleared got %0d want 0", ifc.dec_cw_idx_out); end
`ifdef RS_FRAME_CNT_EN
        vec++; if (ifc.frame_cnt_out !== 16'd1) begin miss++; $display("FAIL dec_frame_cnt got %0d want 1", ifc.frame_cnt_out); end
`endif
    endtask

    task automatic test_sync_err();
        clear_mon();
        send_bytes(0, 499, 1'b1, 3);
        send_bytes(0, 1019, 1'b1, 11);
        tick();
        vec++; if (serr_cnt != 1) begin miss++; $display("FAIL sync_err_count got %0d want 1", serr_cnt); end
        vec++; if (wr_addr_q.size() != 1520) begin miss++; $display("FAIL sync_write_count got %0d want 1520", wr_addr_q.size()); end
        if (wr_addr_q.size() == 1520) begin
            vec++; if (wr_addr_q[500] !== 10'd0 || wr_data_q[500] !== 8'd11)
                begin miss++; $display("FAIL sync_resync_byte got addr %0d data %0h want addr 0 data 0b", wr_addr_q[500], wr_data_q[500]); end
            vec++; if (wr_addr_q[501] !== 10'd255) begin miss++; $display("FAIL sync_addr_k1 got %0d want 255", wr_addr_q[501]); end
            vec++; if (wr_addr_q[1519] !== 10'd1019) begin miss++; $display("FAIL sync_addr_last got %0d want 1019", wr_addr_q[1519]); end
        end
        decode_all(5, 1'b0);
        repeat (2) tick();
        vec++; if (st_idx_q.size() != 4) begin miss++; $display("FAIL sync_start_count got %0d want 4", st_idx_q.size()); end
        vec++; if (fd_cyc_q.size() != 1) begin miss++; $display("FAIL sync_frame_done_count got %0d want 1", fd_cyc_q.size()); end
        vec++; if (serr_cnt != 1) begin miss++; $display("FAIL sync_err_final got %0d want 1", serr_cnt); end
    endtask

    task automatic test_overrun();
        clear_mon();
        send_bytes(0, 1019, 1'b1, 5);
        tick();
        decode_all(10, 1'b1);
        repeat (3) tick();
        vec++; if (ovr_cnt != 3) begin miss++; $display("FAIL ovr_count got %0d want 3", ovr_cnt); end
        vec++; if (wr_addr_q.size() != 1020) begin miss++; $display("FAIL ovr_write_count got %0d want 1020", wr_addr_q.size()); end
        vec++; if (serr_cnt != 0) begin miss++; $display("FAIL ovr_sync_err got %0d want 0", serr_cnt); end
        vec++; if (st_idx_q.size() != 4) begin miss++; $display("FAIL ovr_start_count got %0d want 4", st_idx_q.size()); end
        if (st_idx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                vec++; if (st_idx_q[i] != i) begin miss++; $display("FAIL ovr_start_idx n=%0d got %0d want %0d", i, st_idx_q[i], i); end
            end
        end
        vec++; if (fd_cyc_q.size() != 1) begin miss++; $display("FAIL ovr_frame_done_count got %0d want 1", fd_cyc_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [30:0] obs;
        clear_mon();
        send_bytes(0, 699, 1'b1, 3);
        ifc.byte_valid_in = 1'b1;
        ifc.byte_in       = 8'h77;
        rst_n             = 1'b0;
        tick();
        rst_n = 1'b1;
        obs = {ifc.wr_en_out, ifc.wr_addr_out, ifc.wr_data_out, ifc.dec_start_out,
               ifc.dec_cw_idx_out, ifc.frame_done_out, ifc.overrun_out, ifc.sync_err_out};
        vec++; if (obs !== 25'd0) begin miss++; $display("FAIL rstmid_outputs got %h want 0", obs); end
        send_bytes(701, 800, 1'b0, 3);
        repeat (2) tick();
        vec++; if (wr_addr_q.size() != 700) begin miss++; $display("FAIL rstmid_writes got %0d want 700", wr_addr_q.size()); end
        send_bytes(0, 1019, 1'b1, 9);
        tick();
        vec++; if (wr_addr_q.size() != 1720) begin miss++; $display("FAIL rstmid_refill_count got %0d want 1720", wr_addr_q.size()); end
        if (wr_addr_q.size() == 1720) begin
            vec++; if (wr_addr_q[700] !== 10'd0 || wr_data_q[700] !== 8'd9)
                begin miss++; $display("FAIL rstmid_restart got addr %0d data %0h want addr 0 data 09", wr_addr_q[700], wr_data_q[700]); end
        end
        decode_all(3, 1'b0);
        repeat (2) tick();
        vec++; if (fd_cyc_q.size() != 1) begin miss++; $display("FAIL rstmid_frame_done got %0d want 1", fd_cyc_q.size()); end
        vec++; if (ovr_cnt != 0 || serr_cnt != 0) begin miss++; $display("FAIL rstmid_pulses got ovr %0d serr %0d want 0 0", ovr_cnt, serr_cnt); end
    endtask

    initial begin
        test_reset();
        test_idle_stray();
        test_addr_map();
        test_decode();
        test_sync_err();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
